// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud controller.
// Auto-baud states exist only when UART_AUTOBAUD_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int OS_SHIFT   = 4;
    localparam int DIV_MIN    = 2;

    typedef enum logic [1:0] {
        RUN,
        PEND
`ifdef UART_AUTOBAUD_EN
        ,
        AB_FALL,
        AB_MEAS
`endif
    } baud_state_e;

    // Reset divisor, clamped so a tiny CLK_HZ/BAUD ratio still gives a legal divisor.
    function automatic int reset_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_autobaud_meas.sv
// Auto-baud front end: synchronises rxd, detects the start-bit falling edge
// and counts the low time, saturating at the counter maximum.
module uart_autobaud_meas
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm,
    input  logic                      meas,
    input  logic                      rxd,
    output logic                      fell,
    output logic                      done,
    output logic                      sat,
    output logic [DIV_W+OS_SHIFT-1:0] cnt
);

    localparam int CW = DIV_W + OS_SHIFT;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0] sync;
    logic       rxd_s;
    logic       rxd_q;

    assign rxd_s = sync[1];

    // Line idles high, so sync flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            rxd_q <= 1'b1;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], rxd};
            rxd_q <= rxd_s;
            if (fell)
                cnt <= CW'(1);
            else if (meas && !rxd_s && !sat)
                cnt <= cnt + 1'b1;
        end
    end

    assign fell = arm && rxd_q && !rxd_s;
    assign sat  = (cnt == CNT_MAX);
    assign done = meas && (rxd_s || sat);

endmodule

// File: rtl/uart_baud_ctrl.sv
// UART baud generator with deferred divisor updates (rx 16x tick, tx bit tick).
// Define UART_AUTOBAUD_EN to build in start-bit auto-baud measurement.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             busy,
    output logic             rx_tick,
    output logic             tx_tick,
    output logic [DIV_W-1:0] cur_div,
    input  logic             ab_start,
    input  logic             rxd,
    output logic             ab_done,
    output logic             ab_ok
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(reset_div(CLK_HZ, BAUD_RATE));
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(DIV_MIN);

    baud_state_e      state, state_nxt;
    logic [DIV_W-1:0] rx_cnt;
    logic [DIV_W-1:0] pend_div, pend_nxt;
    logic [3:0]       sub_cnt;
    logic             cfg_fire;
    logic             cfg_bad;
    logic             apply;
    logic             ab_fin;
    logic             ab_good;

    assign cfg_ready = (state == RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign apply     = (state == PEND) && !busy;

    // The apply cycle suppresses ticks so the new rate starts from a clean phase.
    assign rx_tick = !apply && (rx_cnt == cur_div - 1'b1);
    assign tx_tick = rx_tick && (sub_cnt == 4'(OVERSAMPLE - 1));

`ifdef UART_AUTOBAUD_EN
    logic                      ab_fell;
    logic                      ab_end;
    logic                      ab_sat;
    logic [DIV_W+OS_SHIFT-1:0] ab_cnt;
    logic [DIV_W+OS_SHIFT:0]   ab_sum;
    logic [DIV_W:0]            ab_q;
    logic [DIV_W-1:0]          ab_div;
    logic                      ab_div_ok;

    uart_autobaud_meas #(.DIV_W(DIV_W)) u_meas (
        .clk   (clk),
        .rst_n (rst_n),
        .arm   (state == AB_FALL),
        .meas  (state == AB_MEAS),
        .rxd   (rxd),
        .fell  (ab_fell),
        .done  (ab_end),
        .sat   (ab_sat),
        .cnt   (ab_cnt)
    );

    // Round low time to the nearest oversample period; the extra top bit catches overflow.
    assign ab_sum    = {1'b0, ab_cnt} + (DIV_W+OS_SHIFT+1)'(OVERSAMPLE / 2);
    assign ab_q      = ab_sum[DIV_W+OS_SHIFT:OS_SHIFT];
    assign ab_div    = ab_q[DIV_W-1:0];
    assign ab_div_ok = !ab_sat && !ab_q[DIV_W] && (ab_div >= MIN_DIV);
`else
    logic unused_ab;
    assign unused_ab = ab_start ^ rxd;
`endif

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_div;
        cfg_bad   = 1'b0;
        ab_fin    = 1'b0;
        ab_good   = 1'b0;
        case (state)
            RUN: begin
                if (cfg_fire) begin
                    if (cfg_div < MIN_DIV) begin
                        cfg_bad = 1'b1;
                    end else begin
                        pend_nxt  = cfg_div;
                        state_nxt = PEND;
                    end
                end
`ifdef UART_AUTOBAUD_EN
                else if (ab_start) begin
                    state_nxt = AB_FALL;
                end
`endif
            end
            PEND: begin
                if (!busy)
                    state_nxt = RUN;
            end
`ifdef UART_AUTOBAUD_EN
            AB_FALL: begin
                if (ab_fell)
                    state_nxt = AB_MEAS;
            end
            AB_MEAS: begin
                if (ab_end) begin
                    ab_fin = 1'b1;
                    if (ab_div_ok) begin
                        ab_good   = 1'b1;
                        pend_nxt  = ab_div;
                        state_nxt = PEND;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
`endif
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            cur_div  <= RST_DIV;
            pend_div <= RST_DIV;
            rx_cnt   <= '0;
            sub_cnt  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_div <= pend_nxt;
            cfg_err  <= cfg_bad;
            if (apply) begin
                cur_div <= pend_div;
                rx_cnt  <= '0;
                sub_cnt <= '0;
            end else if (rx_tick) begin
                rx_cnt  <= '0;
                sub_cnt <= sub_cnt + 1'b1;
            end else begin
                rx_cnt  <= rx_cnt + 1'b1;
            end
        end
    end

`ifdef UART_AUTOBAUD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ab_done <= 1'b0;
            ab_ok   <= 1'b0;
        end else begin
            ab_done <= ab_fin;
            ab_ok   <= ab_good;
        end
    end
`else
    assign ab_done = 1'b0;
    assign ab_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl; tick and auto-baud results are
// queued as expectations and compared when the DUT produces them.
module tb_uart_baud_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_err;
    logic        busy;
    logic        rx_tick;
    logic        tx_tick;
    logic [15:0] cur_div;
    logic        ab_start;
    logic        rxd;
    logic        ab_done;
    logic        ab_ok;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rx = 0;
    int hold_bad = 0;
    bit hold_on = 0;
    bit ab_seen = 0;
    int exp_rx[$];
    int exp_tx[$];
    int exp_ab[$];

    always #5 clk = ~clk;

    uart_baud_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .rx_tick   (rx_tick),
        .tx_tick   (tx_tick),
        .cur_div   (cur_div),
        .ab_start  (ab_start),
        .rxd       (rxd),
        .ab_done   (ab_done),
        .ab_ok     (ab_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (rx_tick) last_rx = cyc;
        if (hold_on && cur_div !== 16'd325) hold_bad++;
        if (ab_done) ab_seen = 1;
    endtask

    task automatic wait_rx(input int limit);
        int n = 0;
        int e;
        do begin step(); n++; end while (!rx_tick && n < limit);
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : -1;
        if (!rx_tick) check("rx_timeout", 0, 1);
        else          check("rx_cycle", cyc, e);
    endtask

    task automatic wait_tx(input int limit);
        int n = 0;
        int e;
        do begin step(); n++; end while (!tx_tick && n < limit);
        e = (exp_tx.size() > 0) ? exp_tx.pop_front() : -1;
        if (!tx_tick) check("tx_timeout", 0, 1);
        else begin
            check("tx_cycle", cyc, e);
            check("tx_with_rx", rx_tick, 1);
        end
    endtask

    task automatic wait_ab(input int limit);
        int n = 0;
        int e;
        do begin step(); n++; end while (!ab_done && n < limit);
        e = (exp_ab.size() > 0) ? exp_ab.pop_front() : -1;
        if (!ab_done) check("ab_timeout", 0, 1);
        else          check("ab_ok", ab_ok, e);
    endtask

    // Release reset at a negedge; that cycle is numbered 1 (counter at 0).
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        cyc = 1;
    endtask

    initial begin
        int a;
        int hold_start;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; busy = 1'b0;
        ab_start = 1'b0; rxd = 1'b1;

        do_reset();
        check("rst_div", cur_div, 325);
        check("rst_ready", cfg_ready, 1);
        check("rst_rx_tick", rx_tick, 0);
        check("rst_tx_tick", tx_tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ab_done", ab_done, 0);

        exp_rx.push_back(325);
        wait_rx(400);
        check("tx_quiet_first_rx", tx_tick, 0);
        exp_tx.push_back(5200);
        wait_tx(5300);
        exp_tx.push_back(10400);
        wait_tx(5300);

        // Divisor below minimum is rejected with a one-cycle error pulse.
        cfg_valid = 1'b1; cfg_div = 16'd1;
        step();
        cfg_valid = 1'b0;
        check("err_pulse", cfg_err, 1);
        check("err_div", cur_div, 325);
        check("err_ready", cfg_ready, 1);
        step();
        check("err_clear", cfg_err, 0);

        // cfg and ab_start together: cfg wins; busy defers the change.
        cfg_valid = 1'b1; cfg_div = 16'd27; ab_start = 1'b1; busy = 1'b1;
        step();
        cfg_valid = 1'b0; ab_start = 1'b0;
        check("pend_ready", cfg_ready, 0);
        check("pend_div", cur_div, 325);
        hold_on = 1; hold_bad = 0; hold_start = cyc;
        repeat (3) begin
            exp_rx.push_back(last_rx + 325);
            wait_rx(400);
        end
        while (cyc - hold_start < 1000) step();
        hold_on = 0;
        check("hold_div_stable", hold_bad, 0);

        busy = 1'b0;
        #1;
        a = cyc;
        check("apply_no_tick", rx_tick, 0);
        step();
        check("apply_div", cur_div, 27);
        check("apply_ready", cfg_ready, 1);
        exp_rx.push_back(a + 27);
        wait_rx(60);
        exp_tx.push_back(a + 27 * 16);
        wait_tx(500);

        // Reset during PEND discards the pending divisor.
        cfg_valid = 1'b1; cfg_div = 16'd40; busy = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("pend2_ready", cfg_ready, 0);
        rst_n = 1'b0;
        step();
        check("rst_pend_div", cur_div, 325);
        check("rst_pend_state", cfg_ready, 1);
        rst_n = 1'b1; busy = 1'b0;
        cyc = 1;
        exp_rx.push_back(325);
        wait_rx(400);
        check("pend_discard", cur_div, 325);

`ifdef UART_AUTOBAUD_EN
        ab_start = 1'b1;
        step();
        ab_start = 1'b0;
        check("ab_arm", cfg_ready, 0);
        rxd = 1'b0;
        repeat (434) step();
        rxd = 1'b1;
        exp_ab.push_back(1);
        wait_ab(20);
        repeat (3) step();
        check("ab_div_115200", cur_div, 27);

        ab_start = 1'b1;
        step();
        ab_start = 1'b0;
        rxd = 1'b0;
        repeat (20) step();
        rxd = 1'b1;
        exp_ab.push_back(0);
        wait_ab(20);
        repeat (3) step();
        check("ab_short_div", cur_div, 27);
        check("ab_short_ready", cfg_ready, 1);
`else
        ab_seen = 0;
        ab_start = 1'b1; rxd = 1'b0;
        step();
        ab_start = 1'b0;
        check("ab_ignored_ready", cfg_ready, 1);
        repeat (30) step();
        rxd = 1'b1;
        repeat (5) step();
        check("ab_done_quiet", ab_seen, 0);
        check("ab_ok_quiet", ab_ok, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
